// File: rtl/float_div_seq.sv
// rtl/float_div_seq.sv - sequential IEEE-754 single divider, restoring, one quotient bit per clock
module float_div_seq #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  LAST_CNT = 5'(QBITS - 1);

  state_t             state_q;
  logic [24:0]        r_q;
  logic [23:0]        d_q;
  logic [24:0]        q_q;
  logic [4:0]         cnt_q;
  logic signed [9:0]  exp_q;
  logic               sign_q;
  logic               special_q;
  logic [31:0]        pend_res_q;
  logic               pend_inv_q;
  logic               pend_dbz_q;
  logic               pend_ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [31:0]        result_q;
  logic               dbz_q;
  logic               inv_q;
  logic               ovf_q;

  // Operand classification; a zero exponent field (denormal) counts as zero.
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_in;

  assign ea      = A[30:23];
  assign eb      = B[30:23];
  assign fa      = A[22:0];
  assign fb      = B[22:0];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (fa == '0);
  assign b_inf   = (eb == 8'hFF) && (fb == '0);
  assign a_nan   = (ea == 8'hFF) && (fa != '0);
  assign b_nan   = (eb == 8'hFF) && (fb != '0);
  assign sign_in = A[31] ^ B[31];

  logic        spec_hit;
  logic [31:0] spec_res;
  logic        spec_inv;
  logic        spec_dbz;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_res = {sign_in, 31'd0};
    end else if (b_zero) begin
      spec_res = {sign_in, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end else if (a_zero) begin
      spec_res = {sign_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring step; the partial remainder always stays below D, so the shift never loses a bit.
  logic        q_bit;
  logic [24:0] r_rem;
  logic [24:0] r_d;
  logic [24:0] q_d;

  always_comb begin
    q_bit = (r_q >= {1'b0, d_q});
    r_rem = q_bit ? (r_q - {1'b0, d_q}) : r_q;
    r_d   = r_rem << 1;
    q_d   = {q_q[23:0], q_bit};
  end

  logic signed [9:0] exp_n;
  logic [22:0]       mant_n;
  logic [31:0]       norm_res;
  logic              norm_ovf;

  always_comb begin
    if (q_q[24]) begin
      exp_n  = exp_q + 10'sd127;
      mant_n = q_q[23:1];
    end else begin
      exp_n  = exp_q + 10'sd126;
      mant_n = q_q[22:0];
    end
    norm_ovf = 1'b0;
    if (exp_n >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'd0};
      norm_ovf = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      norm_res = {sign_q, 31'd0};
    end else begin
      norm_res = {sign_q, exp_n[7:0], mant_n};
    end
  end

  // Special results pass through NORM untouched so both paths leave through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      pend_res_q <= '0;
      pend_inv_q <= 1'b0;
      pend_dbz_q <= 1'b0;
      pend_ovf_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (!EN) begin
      state_q    <= IDLE;
      r_q        <= '0;
      d_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      pend_res_q <= '0;
      pend_inv_q <= 1'b0;
      pend_dbz_q <= 1'b0;
      pend_ovf_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            sign_q     <= sign_in;
            pend_ovf_q <= 1'b0;
            if (spec_hit) begin
              special_q  <= 1'b1;
              pend_res_q <= spec_res;
              pend_inv_q <= spec_inv;
              pend_dbz_q <= spec_dbz;
              state_q    <= NORM;
            end else begin
              special_q  <= 1'b0;
              pend_inv_q <= 1'b0;
              pend_dbz_q <= 1'b0;
              r_q        <= {1'b0, 1'b1, fa};
              d_q        <= {1'b1, fb};
              q_q        <= '0;
              cnt_q      <= '0;
              exp_q      <= $signed({2'b00, ea}) - $signed({2'b00, eb});
              state_q    <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          if (!special_q) begin
            pend_res_q <= norm_res;
            pend_ovf_q <= norm_ovf;
          end
          state_q <= DONE;
        end
        DONE: begin
          result_q <= pend_res_q;
          inv_q    <= pend_inv_q;
          dbz_q    <= pend_dbz_q;
          ovf_q    <= pend_ovf_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_float_div_seq.sv
// tb/tb_float_div_seq.sv - self-checking bench for float_div_seq: vector table, random model, abort sequences
module tb_float_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EN;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;
  logic        invalid;
  logic        overflow;

  float_div_seq dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero), .invalid(invalid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: classify operands, then divide the significands as integers and truncate.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [2:0] flags, output int lat);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, mant;
    bit     an, ai, az, bn, bi, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    flags = 3'b000;
    lat   = 2;
    if (an || bn || (az && bz) || (ai && bi)) begin
      res = 32'h7FC0_0000; flags = 3'b100;
    end else if (ai) res = {s, 8'hFF, 23'd0};
    else if (bi) res = {s, 31'd0};
    else if (bz) begin res = {s, 8'hFF, 23'd0}; flags = 3'b010; end
    else if (az) res = {s, 31'd0};
    else begin
      lat = 27;
      ma  = longint'({1'b1, a[22:0]});
      mb  = longint'({1'b1, b[22:0]});
      if (ma >= mb) begin
        e = ea - eb + 127; mant = (ma << 23) / mb - 64'sd8388608;
      end else begin
        e = ea - eb + 126; mant = (ma << 24) / mb - 64'sd8388608;
      end
      if (e >= 255) begin res = {s, 8'hFF, 23'd0}; flags = 3'b001; end
      else if (e <= 0) res = {s, 31'd0};
      else res = {s, 8'(e), 23'(mant)};
    end
  endfunction

  function automatic logic [31:0] rnd_fp();
    int sel;
    sel = $urandom_range(0, 19);
    case (sel)
      0:       return {1'($urandom_range(0, 1)), 31'd0};
      1:       return {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
      2:       return {1'b0, 8'hFF, 23'($urandom_range(1, 1000))};
      3:       return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Called on the first sample after the start-accept edge; k counts edges after it.
  task automatic wait_done(input int inj_k, input logic [31:0] ia, input logic [31:0] ib,
                           output int lat, output logic [31:0] res, output logic [2:0] flags,
                           output bit busy_ok);
    lat = -1; res = '0; flags = '0; busy_ok = 1'b1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      if (inj_k >= 0 && k == inj_k + 1) start = 1'b0;
      if (done) begin
        lat = k; res = result; flags = {invalid, div_by_zero, overflow};
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (k == inj_k) begin A = ia; B = ib; start = 1'b1; end
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eres, input logic [2:0] eflags, input int elat,
                          input int inj_k, input logic [31:0] ia, input logic [31:0] ib);
    int          lat;
    logic [31:0] res;
    logic [2:0]  flags;
    bit          busy_ok;
    launch(a, b);
    wait_done(inj_k, ia, ib, lat, res, flags, busy_ok);
    check({name, " result"}, res, eres);
    check({name, " flags"}, 32'(flags), 32'(eflags));
    check({name, " latency"}, lat, elat);
    check({name, " busy until done"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
    check({name, " result"}, result, 32'd0);
    check({name, " flags"}, 32'({invalid, div_by_zero, overflow}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          lat;
    logic [31:0] res;
    logic [31:0] ra, rb;
    logic [2:0]  flags;
    bit          busy_ok;

    rst_n = 1'b0; EN = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    vecs.push_back('{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 27});
    vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 27});
    vecs.push_back('{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b010, 2});
    vecs.push_back('{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 3'b010, 2});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 2});
    vecs.push_back('{32'hC080_0000, 32'h4000_0000, 32'hC000_0000, 3'b000, 27});
    vecs.push_back('{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b001, 27});
    vecs.push_back('{32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 3'b001, 27});
    vecs.push_back('{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 3'b000, 27});
    vecs.push_back('{32'h0100_0000, 32'h4000_0000, 32'h0080_0000, 3'b000, 27});
    vecs.push_back('{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 3'b000, 27});
    vecs.push_back('{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 2});
    vecs.push_back('{32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b100, 2});
    vecs.push_back('{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 3'b000, 2});
    vecs.push_back('{32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 3'b000, 2});
    vecs.push_back('{32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 3'b000, 2});
    vecs.push_back('{32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 3'b000, 2});
    vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 3'b010, 2});
    vecs.push_back('{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 3'b000, 27});

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags,
               vecs[i].lat, -1, '0, '0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] eres;
      logic [2:0]  eflags;
      int          elat;
      ra = rnd_fp();
      rb = rnd_fp();
      model(ra, rb, eres, eflags, elat);
      check_op($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, eres, eflags, elat, -1, '0, '0);
    end

    check_op("pre-reset 6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 27, -1, '0, '0);
    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("reset abort");
    @(negedge clk);
    rst_n = 1'b1;
    count_done(40, cnt);
    check("reset abort no done", cnt, 0);

    check_op("after reset 1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 27, -1, '0, '0);
    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (10) @(negedge clk);
    EN = 1'b0;
    @(negedge clk);
    check_cleared("en abort");
    EN = 1'b1;
    count_done(40, cnt);
    check("en abort no done", cnt, 0);

    check_op("after en 6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 27, -1, '0, '0);
    check_op("busy reject", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 27,
             5, 32'h3F80_0000, 32'h4040_0000);
    count_done(40, cnt);
    check("busy reject no second done", cnt, 0);

    launch(32'h40C0_0000, 32'h4000_0000);
    wait_done(-1, '0, '0, lat, res, flags, busy_ok);
    check("b2b first result", res, 32'h4040_0000);
    A = 32'h3F80_0000; B = 32'h4040_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(-1, '0, '0, lat, res, flags, busy_ok);
    check("b2b second result", res, 32'h3EAA_AAAA);
    check("b2b second latency", lat, 27);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
